// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - press-report link between input_conditioner and the game controller
//
// Signals:
//   IN       colour code of the last accepted press (conditioner -> controller)
//   IN_VALID one-cycle pulse per accepted press       (conditioner -> controller)
//   ENABLE   controller is collecting input           (controller  -> conditioner)
interface input_conditioner_if;
    logic [1:0] IN;
    logic       IN_VALID;
    logic       ENABLE;

    modport master (output IN, output IN_VALID, input ENABLE);
    modport slave  (input IN, input IN_VALID, output ENABLE);
endinterface

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - sync, debounce and single-press encoding of four push buttons
//
// Ports:
//   CLK     system clock, rising edge
//   RST_N   synchronous active-low reset
//   BTN     raw asynchronous button levels, BTN[k] is colour k
//   BTN_DB  debounced button levels
//   CHORD   one-cycle pulse when a multi-button press is rejected
//   ctl     master side of input_conditioner_if (IN, IN_VALID out; ENABLE in)
module input_conditioner #(
    parameter int DB_CYCLES = 1000,
    parameter int CNT_W     = 10
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [3:0]                  BTN,
    output logic [3:0]                  BTN_DB,
    output logic                        CHORD,
    input_conditioner_if.master         ctl
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic {IDLE_S, HELD_S} state_t;

    state_t           state;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [CNT_W-1:0] cnt [4];
    logic [1:0]       in_q;
    logic             in_valid_q;
    logic             chord_q;

    // Exactly one debounced bit set, and the index of the highest set bit.
    logic       any_set;
    logic       one_hot;
    logic [1:0] enc;

    always_comb begin
        any_set = (BTN_DB != 4'b0000);
        one_hot = any_set && ((BTN_DB & (BTN_DB - 4'd1)) == 4'b0000);
        enc     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (BTN_DB[k]) enc = 2'(k);
        end
    end

    // Two-flop synchroniser and per-bit debounce counters.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1  <= 4'b0000;
            sync2  <= 4'b0000;
            BTN_DB <= 4'b0000;
            for (int k = 0; k < 4; k++) cnt[k] <= '0;
        end else begin
            sync1 <= BTN;
            sync2 <= sync1;
            for (int k = 0; k < 4; k++) begin
                if (sync2[k] == BTN_DB[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == DB_LAST) begin
                    BTN_DB[k] <= sync2[k];
                    cnt[k]    <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    // Press acceptance FSM; pulses default low every cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= IDLE_S;
            in_q       <= 2'd0;
            in_valid_q <= 1'b0;
            chord_q    <= 1'b0;
        end else begin
            in_valid_q <= 1'b0;
            chord_q    <= 1'b0;
            case (state)
                IDLE_S: begin
                    if (one_hot) begin
                        // A press already held when ENABLE rises is swallowed here.
                        if (ctl.ENABLE) begin
                            in_q       <= enc;
                            in_valid_q <= 1'b1;
                        end
                        state <= HELD_S;
                    end else if (any_set) begin
                        chord_q <= 1'b1;
                        state   <= HELD_S;
                    end
                end
                HELD_S: begin
                    if (!any_set) state <= IDLE_S;
                end
                default: state <= IDLE_S;
            endcase
        end
    end

    assign ctl.IN       = in_q;
    assign ctl.IN_VALID = in_valid_q;
    assign CHORD        = chord_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] BTN;
    logic [3:0] BTN_DB;
    logic       CHORD;

    int vectors    = 0;
    int miscompares = 0;
    int iv_cnt     = 0;
    int chord_cnt  = 0;

    input_conditioner_if ctl_if ();

    input_conditioner #(.DB_CYCLES(4), .CNT_W(2)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .BTN    (BTN),
        .BTN_DB (BTN_DB),
        .CHORD  (CHORD),
        .ctl    (ctl_if.master)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (ctl_if.IN_VALID === 1'b1) iv_cnt++;
        if (CHORD === 1'b1) chord_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int iv0;
        int ch0;
        RST_N = 1'b0;
        BTN = 4'b0000;
        ctl_if.ENABLE = 1'b1;
        tick(2);
        chk("rst_in", ctl_if.IN, 2'd0);
        chk("rst_iv", ctl_if.IN_VALID, 1'b0);
        chk("rst_db", BTN_DB, 4'b0000);
        chk("rst_chord", CHORD, 1'b0);

        // Single press of colour 2 with exact latency.
        RST_N = 1'b1;
        BTN = 4'b0100;
        tick(5);
        chk("p2_db_early", BTN_DB, 4'b0000);
        tick(1);
        chk("p2_db", BTN_DB, 4'b0100);
        chk("p2_iv_early", ctl_if.IN_VALID, 1'b0);
        tick(1);
        chk("p2_iv", ctl_if.IN_VALID, 1'b1);
        chk("p2_in", ctl_if.IN, 2'd2);
        tick(1);
        chk("p2_iv_end", ctl_if.IN_VALID, 1'b0);
        tick(10);
        chk("p2_count", iv_cnt, 1);
        BTN = 4'b0000;
        tick(8);
        chk("p2_release", BTN_DB, 4'b0000);

        // Three-cycle glitch never debounces.
        iv0 = iv_cnt;
        BTN = 4'b0010;
        tick(3);
        BTN = 4'b0000;
        tick(10);
        chk("glitch_db", BTN_DB, 4'b0000);
        chk("glitch_iv", iv_cnt, iv0);

        // Chord, partial release, full release, then single press of colour 3.
        ch0 = chord_cnt;
        BTN = 4'b1001;
        tick(7);
        chk("chord_pulse", CHORD, 1'b1);
        chk("chord_iv", ctl_if.IN_VALID, 1'b0);
        chk("chord_in_hold", ctl_if.IN, 2'd2);
        tick(1);
        chk("chord_end", CHORD, 1'b0);
        BTN = 4'b1000;
        tick(10);
        chk("chord_partial_db", BTN_DB, 4'b1000);
        chk("chord_partial_iv", iv_cnt, iv0);
        chk("chord_count", chord_cnt, ch0 + 1);
        BTN = 4'b0000;
        tick(8);
        BTN = 4'b1000;
        tick(7);
        chk("p3_iv", ctl_if.IN_VALID, 1'b1);
        chk("p3_in", ctl_if.IN, 2'd3);
        BTN = 4'b0000;
        tick(8);

        // Press held while ENABLE rises is swallowed.
        iv0 = iv_cnt;
        ctl_if.ENABLE = 1'b0;
        BTN = 4'b0001;
        tick(10);
        ctl_if.ENABLE = 1'b1;
        tick(10);
        chk("swallow_iv", iv_cnt, iv0);
        BTN = 4'b0000;
        tick(8);
        BTN = 4'b0001;
        tick(7);
        chk("p0_iv", ctl_if.IN_VALID, 1'b1);
        chk("p0_in", ctl_if.IN, 2'd0);
        BTN = 4'b0000;
        tick(8);

        // Staggered press: second button ignored.
        iv0 = iv_cnt;
        ch0 = chord_cnt;
        BTN = 4'b0100;
        tick(6);
        chk("stag_db1", BTN_DB, 4'b0100);
        tick(1);
        chk("stag_iv", ctl_if.IN_VALID, 1'b1);
        chk("stag_in", ctl_if.IN, 2'd2);
        tick(1);
        BTN = 4'b0110;
        tick(10);
        chk("stag_db2", BTN_DB, 4'b0110);
        chk("stag_count", iv_cnt, iv0 + 1);
        chk("stag_chord", chord_cnt, ch0);
        BTN = 4'b0000;
        tick(8);

        // Reset in the middle of a debounce count.
        BTN = 4'b1000;
        tick(3);
        RST_N = 1'b0;
        tick(1);
        chk("mrst_in", ctl_if.IN, 2'd0);
        chk("mrst_iv", ctl_if.IN_VALID, 1'b0);
        chk("mrst_db", BTN_DB, 4'b0000);
        chk("mrst_chord", CHORD, 1'b0);
        RST_N = 1'b1;
        tick(6);
        chk("mrst_iv_early", ctl_if.IN_VALID, 1'b0);
        tick(1);
        chk("mrst_iv", ctl_if.IN_VALID, 1'b1);
        chk("mrst_in3", ctl_if.IN, 2'd3);
        tick(1);
        chk("mrst_iv_end", ctl_if.IN_VALID, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Front-end stage directly upstream of the game controller. It turns four raw, asynchronous push-button levels into the controller's IN / IN_VALID interface. Each button is synchronised and debounced. A press is accepted only when exactly one button is held, and it is emitted as a single-cycle IN_VALID pulse carrying a 2-bit colour code. No further press is accepted until all buttons are released.

Parameters:
DB_CYCLES, 1000, consecutive stable synchronised cycles required before a debounced level changes (minimum 1)
CNT_W, 10, width of each debounce counter; must satisfy 2**CNT_W >= DB_CYCLES

Ports:
CLK  input  1  system clock; all logic on rising edge
RST_N  input  1  reset, synchronous, active-low
BTN  input  4  raw button levels, active-high, asynchronous to CLK; BTN[k] is colour k
ENABLE  input  1  high while the controller is in its input-collection state
IN  output  2  encoded colour of the last accepted press; valid when IN_VALID=1, held otherwise
IN_VALID  output  1  one-cycle pulse per accepted press
BTN_DB  output  4  debounced button levels, for LED echo
CHORD  output  1  one-cycle pulse when a multi-button press is rejected

Behaviour:
- Reset: single clock; reset is synchronous and active-low. On any rising CLK edge with RST_N=0, clear all state: sync flops, BTN_DB, counters, state=IDLE_S, IN=0, IN_VALID=0, CHORD=0. RST_N low mid-operation drops any pending pulse.
- Synchroniser: two-flop chain per bit, sync1<=BTN then sync2<=sync1. No other logic reads BTN.
- Debounce, per bit k, with s=sync2[k] and d=BTN_DB[k]:
  - if s==d: cnt[k]<=0.
  - if s!=d and cnt[k]==DB_CYCLES-1: d<=s and cnt[k]<=0.
  - otherwise: cnt[k]<=cnt[k]+1.
  - Any glitch shorter than DB_CYCLES sync cycles resets the count and never changes d.
- Latency: let E0 be the first edge that samples BTN[k] high, with BTN held stable.
  - BTN_DB[k] goes high after edge E0+DB_CYCLES+1.
  - IN_VALID goes high after edge E0+DB_CYCLES+2 and lasts exactly one cycle.
  - Release follows the same timing for BTN_DB.
- FSM states IDLE_S and HELD_S. Both IN_VALID and CHORD default to 0 every cycle.
  - IDLE_S, BTN_DB==0: stay.
  - IDLE_S, exactly one bit of BTN_DB set, ENABLE=1: IN<=index of the set bit (BTN[0]->0 ... BTN[3]->3), IN_VALID<=1, go to HELD_S.
  - IDLE_S, exactly one bit set, ENABLE=0: go to HELD_S with no pulse. The press is swallowed, so a button held while ENABLE rises is never reported.
  - IDLE_S, two or more bits set: CHORD<=1 for one cycle, no IN_VALID, go to HELD_S.
  - HELD_S: stay until BTN_DB==0, then go to IDLE_S on the next edge. Extra buttons pressed while in HELD_S are ignored and produce no CHORD.
- Staggered presses: if one debounced bit rises and a second rises on a later cycle, the first is accepted and the second is ignored.
- IN is updated only on acceptance and holds its value otherwise.
- IN_VALID and CHORD are never high in the same cycle.
- At most one IN_VALID per press-release cycle.
- ENABLE is only sampled in IDLE_S; changing it during HELD_S has no effect.
- Implementation size: four counters of CNT_W bits, a popcount/encoder and a 2-state FSM, roughly 150-250 lines.

Test Plan:
- DB_CYCLES=4, ENABLE=1, BTN=4'b0100 held from edge E0 -> BTN_DB[2] high after E5; IN_VALID=1 with IN=2'd2 for exactly one cycle after E6; no further pulse while the button is held.
- DB_CYCLES=4, BTN[1] pulsed high for 3 cycles, then low -> BTN_DB stays 0, IN_VALID never asserts.
- DB_CYCLES=4, BTN=4'b1001 applied on the same edge -> CHORD one-cycle pulse, IN_VALID stays 0; then BTN[0] released alone with BTN[3] still held -> no pulse; release all, then press BTN[3] alone -> IN_VALID with IN=2'd3.
- ENABLE=0 and BTN[0] pressed and held, then ENABLE=1 while still held -> no IN_VALID; release, then press BTN[0] again -> IN_VALID with IN=0.
- Press BTN[2]; two cycles after BTN_DB[2] rises, press BTN[1] -> exactly one IN_VALID with IN=2; no CHORD.
- RST_N driven low for 1 cycle while cnt[3] is mid-count -> next cycle all outputs 0 and counters 0; with BTN[3] still held, IN_VALID with IN=3 after DB_CYCLES+2 further edges.
